// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetcher.
// Default entry layout matches XLEN=ILEN=32.
package prefetch_pkg;

  localparam int PF_XLEN = 32;
  localparam int PF_ILEN = 32;

  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [2:0] AXI_ARPROT_INSTR = 3'b100;

  typedef struct packed {
    logic                fault;
    logic [PF_XLEN-1:0]  pc;
    logic [PF_ILEN-1:0]  instr;
  } fetch_entry_t;

  function automatic logic resp_is_fault(input logic [1:0] rresp);
    return rresp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/prefetch_unit_if.sv
// AXI-lite bus bundle; the prefetcher uses the read channels and ties off writes.
interface if_axi_lite #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [2:0]          arprot;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [2:0]          awprot;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport M (
    output araddr, arvalid, arprot, rready, awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport S (
    input  araddr, arvalid, arprot, rready, awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/prefetch_unit_fetch_fifo.sv
// Generic synchronous FIFO with flush, occupancy count and registered head.
// Latency: a push is visible at the head the next cycle; flush wins over push/pop.
module fetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic                       head_vld,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // Full is still writable when the head leaves in the same cycle.
  assign do_push = push && ((count != CNTW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNTW'(do_push) - CNTW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !(rst || flush)) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign head_vld = (count != '0);

endmodule

// File: rtl/prefetch_unit.sv
// Sequential instruction prefetcher with credit-limited AXI-lite reads and redirect flush.
// Latency: R handshake to head valid is 1 cycle; optional PREFETCH_PERF_EN adds perf counters.
module prefetch_unit
  import prefetch_pkg::*;
#(
  parameter int          XLEN            = 32,
  parameter int          ILEN            = 32,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_instr_valid,
  input  logic            i_instr_ready,
  output logic [ILEN-1:0] o_instr_data,
  output logic [XLEN-1:0] o_instr_pc,
  output logic            o_instr_fault,
  output logic            o_busy,
  if_axi_lite.M           m_axi
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0]     o_perf_fetched,
  output logic [31:0]     o_perf_stall
`endif
);
  localparam int QW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = QW + 1;
  localparam int EW = 1 + XLEN + ILEN;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(ILEN / 8);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] ar_addr;
  logic            ar_vld;
  logic            stale_ar;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [QW-1:0]   q_count;
  logic [CW-1:0]   in_flight_next;
  logic [XLEN-1:0] pc_adv;
  logic            ar_hs;
  logic            r_hs;
  logic            credit;
  logic            push;
  logic            pop;
  logic [EW-1:0]   push_dat;
  logic [EW-1:0]   head_dat;

  assign ar_hs = ar_vld && m_axi.arready;
  assign r_hs  = m_axi.rvalid && m_axi.rready;
  assign pop   = o_instr_valid && i_instr_ready;

  assign in_flight_next = outstanding + CW'(ar_hs) - CW'(r_hs);

  // Credit counts an AR handshaking this cycle so arvalid can stay up back-to-back.
  assign credit = ((outstanding + CW'(q_count) + CW'(ar_hs)) < CW'(FIFO_DEPTH)) &&
                  ((outstanding + CW'(ar_hs)) < CW'(MAX_OUTSTANDING));

  // A stale AR was issued for the old stream, so it must not advance the new PC.
  assign pc_adv = (ar_hs && !stale_ar) ? pc + PC_STEP : pc;

  assign push     = r_hs && (discard == '0) && !i_redirect_valid;
  assign push_dat = {resp_is_fault(m_axi.rresp), resp_pc, m_axi.rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      ar_addr     <= RESET_PC;
      ar_vld      <= 1'b0;
      stale_ar    <= 1'b0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= in_flight_next;

      if (ar_vld && !m_axi.arready) begin
        ar_vld <= 1'b1;
      end else begin
        ar_vld <= credit && !i_redirect_valid;
        if (credit && !i_redirect_valid) ar_addr <= pc_adv;
      end

      if (i_redirect_valid) begin
        pc       <= i_redirect_pc;
        resp_pc  <= i_redirect_pc;
        discard  <= in_flight_next;
        stale_ar <= ar_vld && !m_axi.arready;
      end else begin
        pc <= pc_adv;
        if (push) resp_pc <= resp_pc + PC_STEP;
        discard <= discard + CW'(stale_ar && ar_hs) - CW'(r_hs && (discard != '0));
        if (ar_hs) stale_ar <= 1'b0;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (i_redirect_valid),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .head_vld (o_instr_valid),
    .count    (q_count)
  );

  assign o_instr_fault = head_dat[EW-1];
  assign o_instr_pc    = head_dat[ILEN +: XLEN];
  assign o_instr_data  = head_dat[ILEN-1:0];
  assign o_busy        = ar_vld || (outstanding != '0);

  assign m_axi.araddr  = ar_addr;
  assign m_axi.arvalid = ar_vld;
  assign m_axi.arprot  = AXI_ARPROT_INSTR;
  assign m_axi.rready  = 1'b1;
  assign m_axi.awaddr  = '0;
  assign m_axi.awvalid = 1'b0;
  assign m_axi.awprot  = '0;
  assign m_axi.wdata   = '0;
  assign m_axi.wstrb   = '0;
  assign m_axi.wvalid  = 1'b0;
  assign m_axi.bready  = 1'b1;

`ifdef PREFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_perf_fetched <= '0;
      o_perf_stall   <= '0;
    end else begin
      if (pop) o_perf_fetched <= o_perf_fetched + 32'd1;
      if (!o_instr_valid && i_instr_ready) o_perf_stall <= o_perf_stall + 32'd1;
    end
  end
`endif

endmodule
